// File: rtl/instruction_queue_pkg.sv
// Shared widths, constants and entry type for the instruction queue.
package instruction_queue_pkg;

  localparam int unsigned WordW          = 32;
  localparam int unsigned IqDepthDefault = 16;

  localparam logic [WordW-1:0] ZeroWord = '0;
  localparam logic [WordW-1:0] PcStep   = 32'd4;

  typedef struct packed {
    logic [WordW-1:0] pc;
    logic [WordW-1:0] instr;
  } iq_entry_t;

endpackage

// File: rtl/instruction_queue.sv
// Fetch-address generator plus circular {pc, instruction} FIFO feeding the dispatcher.
// A jump flushes the queue and discards the one stale fetch that may still be in flight.
module instruction_queue
  import instruction_queue_pkg::*;
#(
  parameter int unsigned IQ_DEPTH = IqDepthDefault
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WordW-1:0] ib_address_out,
  input  logic             ib_ready_in,
  input  logic [WordW-1:0] ib_instruction_in,
  output logic             dsp_valid_out,
  input  logic             dsp_ready_in,
  output logic [WordW-1:0] dsp_instruction_out,
  output logic [WordW-1:0] dsp_pc_out,
  input  logic             jump_in,
  input  logic [WordW-1:0] jump_address_in
);

  localparam int unsigned      PtrW    = $clog2(IQ_DEPTH);
  localparam int unsigned      CntW    = PtrW + 1;
  localparam logic [CntW-1:0]  FullCnt = CntW'(IQ_DEPTH);

  logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [WordW-1:0] fetch_pc_q, fetch_pc_d;
  logic             drop_next_q, drop_next_d;

  iq_entry_t mem_q [IQ_DEPTH];

  logic empty, full, pop, push, wr_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == FullCnt);
  assign pop   = !empty && dsp_ready_in;
  // Fullness is judged at cycle start, so a same-cycle pop never makes room.
  assign push  = ib_ready_in && !drop_next_q && !full;
  assign wr_en = push && !jump_in;

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    fetch_pc_d  = fetch_pc_q;
    drop_next_d = drop_next_q;
    if (jump_in) begin
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      fetch_pc_d  = jump_address_in;
      // No arrival this cycle means the stale-PC fetch is still outstanding.
      drop_next_d = !ib_ready_in;
    end else begin
      if (ib_ready_in && drop_next_q) begin
        drop_next_d = 1'b0;
      end
      if (push) begin
        tail_d     = tail_q + PtrW'(1);
        fetch_pc_d = fetch_pc_q + PcStep;
      end
      if (pop) begin
        head_d = head_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      fetch_pc_q  <= ZeroWord;
      drop_next_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      fetch_pc_q  <= fetch_pc_d;
      drop_next_q <= drop_next_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[tail_q] <= '{pc: fetch_pc_q, instr: ib_instruction_in};
    end
  end

  assign ib_address_out      = fetch_pc_q;
  assign dsp_valid_out       = !empty;
  assign dsp_instruction_out = empty ? ZeroWord : mem_q[head_q].instr;
  assign dsp_pc_out          = empty ? ZeroWord : mem_q[head_q].pc;

endmodule

// File: tb/tb_instruction_queue.sv
// Self-checking bench for instruction_queue: vector table plus scoreboarded corner sequences.
module tb_instruction_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ib_address_out;
  logic        ib_ready_in = 1'b0;
  logic [31:0] ib_instruction_in = '0;
  logic        dsp_valid_out;
  logic        dsp_ready_in = 1'b0;
  logic [31:0] dsp_instruction_out;
  logic [31:0] dsp_pc_out;
  logic        jump_in = 1'b0;
  logic [31:0] jump_address_in = '0;

  instruction_queue #(.IQ_DEPTH(16)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .ib_address_out      (ib_address_out),
    .ib_ready_in         (ib_ready_in),
    .ib_instruction_in   (ib_instruction_in),
    .dsp_valid_out       (dsp_valid_out),
    .dsp_ready_in        (dsp_ready_in),
    .dsp_instruction_out (dsp_instruction_out),
    .dsp_pc_out          (dsp_pc_out),
    .jump_in             (jump_in),
    .jump_address_in     (jump_address_in)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
  } vec_t;

  ent_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check_head();
    ent_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_underflow: got pop with empty scoreboard expected entry");
    end else begin
      e = sb.pop_front();
      chk("dsp_valid", {31'd0, dsp_valid_out}, 32'd1);
      chk("dsp_pc", dsp_pc_out, e.pc);
      chk("dsp_instr", dsp_instruction_out, e.instr);
    end
  endtask

  // One clock cycle; called #1 after a rising edge, returns #1 after the next.
  task automatic step(input logic arr, input logic [31:0] instr, input logic rdy,
                      input logic jmp, input logic [31:0] jaddr);
    if (rdy && !jmp) check_head();
    ib_ready_in       = arr;
    ib_instruction_in = instr;
    dsp_ready_in      = rdy;
    jump_in           = jmp;
    jump_address_in   = jaddr;
    @(posedge clk);
    #1;
    ib_ready_in  = 1'b0;
    dsp_ready_in = 1'b0;
    jump_in      = 1'b0;
  endtask

  task automatic drain();
    while (sb.size() > 0) step(1'b0, '0, 1'b1, 1'b0, '0);
    chk("empty_after_drain", {31'd0, dsp_valid_out}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{instr: 32'h0000_0013, exp_pc: 32'h0, exp_addr: 32'h4};
    vecs[1] = '{instr: 32'h0010_0093, exp_pc: 32'h4, exp_addr: 32'h8};
    vecs[2] = '{instr: 32'h0020_0113, exp_pc: 32'h8, exp_addr: 32'hC};
    vecs[3] = '{instr: 32'h0030_8193, exp_pc: 32'hC, exp_addr: 32'h10};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_addr", ib_address_out, 32'h0);
    chk("reset_valid", {31'd0, dsp_valid_out}, 32'd0);
    chk("reset_instr", dsp_instruction_out, 32'h0);
    chk("reset_pc", dsp_pc_out, 32'h0);
    rst = 1'b0;

    // Free-run: table-driven arrivals, then in-order dispatch.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, vecs[i].instr, 1'b0, 1'b0, '0);
      sb.push_back('{pc: vecs[i].exp_pc, instr: vecs[i].instr});
      chk("vec_fetch_addr", ib_address_out, vecs[i].exp_addr);
    end
    drain();

    // Fill to 16, overflow with coincident pop is dropped, refetch accepted.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 32'hA000_0000 + 32'(i), 1'b0, 1'b0, '0);
      sb.push_back('{pc: 32'(i) * 32'd4, instr: 32'hA000_0000 + 32'(i)});
    end
    chk("full_addr", ib_address_out, 32'h40);
    step(1'b1, 32'hDEAD_0017, 1'b1, 1'b0, '0);
    chk("overflow_addr", ib_address_out, 32'h40);
    step(1'b1, 32'hBEEF_0040, 1'b0, 1'b0, '0);
    sb.push_back('{pc: 32'h40, instr: 32'hBEEF_0040});
    chk("refetch_addr", ib_address_out, 32'h44);
    drain();

    // Jump with no coincident arrival: next arrival is stale.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 32'hB000_0000 + 32'(i), 1'b0, 1'b0, '0);
      sb.push_back('{pc: 32'(i) * 32'd4, instr: 32'hB000_0000 + 32'(i)});
    end
    step(1'b0, '0, 1'b1, 1'b1, 32'h100);
    sb.delete();
    chk("jump1_valid", {31'd0, dsp_valid_out}, 32'd0);
    chk("jump1_addr", ib_address_out, 32'h100);
    step(1'b1, 32'h0000_0111, 1'b0, 1'b0, '0);
    chk("jump1_stale_valid", {31'd0, dsp_valid_out}, 32'd0);
    chk("jump1_stale_addr", ib_address_out, 32'h100);
    step(1'b1, 32'h0000_0222, 1'b0, 1'b0, '0);
    sb.push_back('{pc: 32'h100, instr: 32'h0000_0222});
    chk("jump1_next_addr", ib_address_out, 32'h104);
    drain();

    // Jump coincident with an arrival: that arrival is the discarded one.
    step(1'b1, 32'h0000_0555, 1'b0, 1'b0, '0);
    sb.push_back('{pc: 32'h104, instr: 32'h0000_0555});
    step(1'b1, 32'h0000_0333, 1'b1, 1'b1, 32'h200);
    sb.delete();
    chk("jump2_valid", {31'd0, dsp_valid_out}, 32'd0);
    chk("jump2_addr", ib_address_out, 32'h200);
    step(1'b1, 32'h0000_0444, 1'b0, 1'b0, '0);
    sb.push_back('{pc: 32'h200, instr: 32'h0000_0444});
    chk("jump2_next_addr", ib_address_out, 32'h204);
    drain();

    // Steady push+pop at count 5, head and tail wrap past index 15.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'hC000_0000 + 32'(i), 1'b0, 1'b0, '0);
      sb.push_back('{pc: 32'(i) * 32'd4, instr: 32'hC000_0000 + 32'(i)});
    end
    for (int k = 5; k < 25; k++) begin
      step(1'b1, 32'hC000_0000 + 32'(k), 1'b1, 1'b0, '0);
      sb.push_back('{pc: 32'(k) * 32'd4, instr: 32'hC000_0000 + 32'(k)});
    end
    chk("wrap_addr", ib_address_out, 32'h64);
    chk("wrap_sb_depth", 32'(sb.size()), 32'd5);
    drain();

    // Asynchronous reset mid-fill at count 7, with a coincident arrival.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 32'hD000_0000 + 32'(i), 1'b0, 1'b0, '0);
    end
    chk("prerst_valid", {31'd0, dsp_valid_out}, 32'd1);
    #2;
    rst = 1'b1;
    ib_ready_in = 1'b1;
    ib_instruction_in = 32'hD000_00FF;
    #1;
    chk("async_rst_valid", {31'd0, dsp_valid_out}, 32'd0);
    chk("async_rst_instr", dsp_instruction_out, 32'h0);
    chk("async_rst_pc", dsp_pc_out, 32'h0);
    chk("async_rst_addr", ib_address_out, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ib_ready_in = 1'b0;
    sb.delete();
    chk("post_rst_valid", {31'd0, dsp_valid_out}, 32'd0);
    chk("post_rst_addr", ib_address_out, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instruction_queue.md
INSTRUCTION_QUEUE -- requirements
Module: instruction_queue

Interface
REQ-001 SHALL provide parameter IQ_DEPTH, default 16, meaning the number of {pc, instruction} entries; it is a power of two and at least 2.
REQ-002 SHALL provide port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL provide port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL provide port ib_address_out, output, 32 bits: the fetch PC, sampled by the instruction buffer in its idle cycle.
REQ-005 SHALL provide port ib_ready_in, input, 1 bit: a one-cycle pulse marking ib_instruction_in as valid.
REQ-006 SHALL provide port ib_instruction_in, input, 32 bits: the fetched instruction word.
REQ-007 SHALL provide port dsp_valid_out, output, 1 bit: the head entry is presented to the dispatcher.
REQ-008 SHALL provide port dsp_ready_in, input, 1 bit: the dispatcher accepts the head entry this cycle.
REQ-009 SHALL provide port dsp_instruction_out, output, 32 bits: the head instruction.
REQ-010 SHALL provide port dsp_pc_out, output, 32 bits: the head PC.
REQ-011 SHALL provide port jump_in, input, 1 bit: a one-cycle redirect/flush request.
REQ-012 SHALL provide port jump_address_in, input, 32 bits: the redirect target PC.

Function
REQ-013 SHALL hold a circular FIFO with head/tail pointers of log2(IQ_DEPTH) bits that wrap modulo IQ_DEPTH, and a count of log2(IQ_DEPTH)+1 bits; full means count==IQ_DEPTH, empty means count==0.
REQ-014 SHALL drive dsp_valid_out = !empty and dsp_instruction_out/dsp_pc_out = head entry combinationally; when empty these are zero.
REQ-015 SHALL pop the head when dsp_valid_out && dsp_ready_in: head+1, count-1.
REQ-016 SHALL accept an arrival (ib_ready_in && !drop_next && !jump_in): if not full at cycle start, write {fetch_pc, ib_instruction_in} at tail, tail+1, count+1, fetch_pc += 4 (mod 2^32).
REQ-017 SHALL discard an arrival when full at cycle start and leave fetch_pc unchanged, so the same address is fetched again; a simultaneous pop does not admit it.
REQ-018 SHALL apply push and pop in the same cycle, leaving count unchanged.
REQ-019 SHALL drive ib_address_out = fetch_pc (registered).
REQ-020 SHALL on jump_in empty the queue (head=tail=0, count=0), set fetch_pc = jump_address_in, and suppress any pop that cycle.
REQ-021 SHALL on jump_in set flag drop_next=1 when ib_ready_in is low that cycle (a fetch of the stale PC is outstanding), and drop_next=0 when ib_ready_in is high that cycle (that arrival is discarded and the next fetch samples the new PC).
REQ-022 SHALL discard the next ib_ready_in arrival while drop_next=1, clear drop_next, and leave the queue and fetch_pc untouched.
REQ-023 SHALL give jump_in priority over push, pop and drop_next handling in the same cycle.
REQ-024 SHALL keep at most one fetch in flight, guaranteed by the buffer protocol; no other outstanding tracking is required.

Reset
REQ-025 SHALL on rst asynchronously clear head, tail, count and drop_next and set fetch_pc=0, giving ib_address_out=0, dsp_valid_out=0, dsp_instruction_out=0 and dsp_pc_out=0.
REQ-026 SHALL leave storage array contents unreset; they are unobservable while the queue is empty.
REQ-027 SHALL discard any arrival pulse coincident with rst.

Structure
REQ-028 SHALL take WORD_RANGE, INSTRUCTION_RANGE, ZERO_WORD, TRUE/FALSE and a new IQ_DEPTH default from the shared header.v.
REQ-029 SHALL implement storage inline; no sub-module is needed.

Verification
REQ-030 SHALL cover reset then free-run: arrivals 0x00000013, 0x00100093 -> entries pc 0x0 and 0x4 dispatched in order, ib_address_out=0x8.
REQ-031 SHALL cover fill with dsp_ready_in=0: 16 arrivals -> count 16; 17th arrival dropped, ib_address_out stays 0x40; after one pop the refetch of 0x40 is accepted.
REQ-032 SHALL cover jump_in (target 0x100) with no coincident arrival: queue empties, next arrival discarded, following arrival stored with pc 0x100.
REQ-033 SHALL cover jump_in (target 0x200) coincident with ib_ready_in: arrival discarded, next arrival stored with pc 0x200.
REQ-034 SHALL cover simultaneous push and pop at count 5: count stays 5 and order is preserved across pointer wrap past index 15.
REQ-035 SHALL cover rst asserted mid-fill with count 7: outputs zero immediately, ib_address_out=0.
